fft4_sched: RTL and testbench

Frame sequencer for the serial 4-point FFT datapath (`fft_4point`). It accepts input samples over a valid/ready stream and feeds them to the datapath one per cycle on `a`. It generates the `sel`/`sel_1` stage-select schedule, captures the four results from `y`, and emits them as a framed output stream with status counters. It sits between the sample source and `fft_4point` and is the only driver of that datapath's `a`, `sel` and `sel_1` inputs.

---
 rtl/fft4_pkg.sv | 24 ++
 rtl/fft4_sel_gen.sv | 32 +++
 rtl/fft4_sched.sv | 138 +++++++++++++
 tb/tb_fft4_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point FFT frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fft4_pkg;

    // Frame phases: waiting for x0, feeding x0..x3, flushing the datapath.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FRAME_STEPS = 8;
    localparam int N_PTS       = 4;
    localparam int SEL_DELAY   = 2;

    localparam int STEP_W = $clog2(FRAME_STEPS);

    // Step at which the last sample of a frame sits on the datapath input.
    localparam logic [STEP_W-1:0] LAST_LOAD_STEP = STEP_W'(N_PTS - 1);
    // Final step of a frame; the only DRAIN step that can accept a new x0.
    localparam logic [STEP_W-1:0] LAST_STEP      = STEP_W'(FRAME_STEPS - 1);

endpackage

// File: rtl/fft4_sel_gen.sv
// Stage-select generator: sel from the frame step, sel_1 as sel delayed SEL_DELAY cycles.
// Latency: sel is combinational from step; sel_1 lags sel by SEL_DELAY cycles.
// Backpressure: none; the delay line shifts every cycle, idle or not.
module fft4_sel_gen
    import fft4_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              active,
    input  logic [STEP_W-1:0] step,
    output logic              sel,
    output logic              sel_1
);

    logic [SEL_DELAY-1:0] sel_sr;

    // First stage alternates every two steps and is parked low while idle.
    assign sel = active & step[1];

    // Second-stage select is the first-stage select seen SEL_DELAY cycles later;
    // it keeps shifting in IDLE so a back-to-back frame inherits the previous tail.
    always_ff @(posedge clk) begin
        if (clear) begin
            sel_sr <= '0;
        end else begin
            sel_sr <= {sel_sr[SEL_DELAY-2:0], sel};
        end
    end

    assign sel_1 = sel_sr[SEL_DELAY-1];

endmodule

// File: rtl/fft4_sched.sv
// Frame sequencer for the serial 4-point FFT: feeds a/sel/sel_1, captures y, frames results.
// Latency: x0 accepted to r0 on out_data/out_valid is LAT+2 cycles; frame period 8 cycles.
// Backpressure: in_ready is the only stall point; output stream has none and frames never stall.
module fft4_sched
    import fft4_pkg::*;
#(
    parameter int DW  = 4,
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] a,
    output logic          sel,
    output logic          sel_1,
    input  logic [DW-1:0] y,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          underrun,
    output logic [7:0]    frame_count
);

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nxt;
    logic              ready_raw;
    logic              accept;
    logic              active;
    logic [STEP_W-1:0] cap_idx;
    logic              capture;
    logic              cap_last;

    // FSM state register: phase plus the 3-bit frame step counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next-state logic: the step counter free-runs through a frame because the
    // datapath has no enable; only step 7 decides between a new frame and IDLE.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: begin
                step_nxt = '0;
                if (in_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                step_nxt = step + STEP_W'(1);
                if (step == LAST_LOAD_STEP) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                step_nxt = step + STEP_W'(1);
                if (step == LAST_STEP) begin
                    step_nxt  = '0;
                    state_nxt = in_valid ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    // FSM outputs: ready only in cycles whose accepted sample lands on a next cycle.
    always_comb begin
        ready_raw = 1'b0;
        case (state)
            IDLE:    ready_raw = 1'b1;
            LOAD:    ready_raw = (step != LAST_LOAD_STEP);
            DRAIN:   ready_raw = (step == LAST_STEP);
            default: ready_raw = 1'b0;
        endcase
        in_ready = ready_raw & ~clear;
        busy     = (state != IDLE);
    end

    assign accept = in_valid & in_ready;
    assign active = (state != IDLE);

    // Results r0..r3 emerge from the datapath at steps LAT..LAT+3. The modular
    // offset from LAT is below N_PTS exactly inside that window for LAT in 1..4.
    assign cap_idx  = step - STEP_W'(LAT);
    assign capture  = active & (cap_idx < STEP_W'(N_PTS));
    assign cap_last = capture & (cap_idx == LAST_LOAD_STEP);

    fft4_sel_gen u_sel_gen (
        .clk    (clk),
        .clear  (clear),
        .active (active),
        .step   (step),
        .sel    (sel),
        .sel_1  (sel_1)
    );

    // Datapath feed, result capture and status: a missing mid-frame sample is
    // replaced by zero and flagged, since the frame cannot wait for it.
    always_ff @(posedge clk) begin
        if (clear) begin
            a           <= '0;
            underrun    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            frame_count <= '0;
        end else begin
            a <= accept ? in_data : '0;
            if ((state == LOAD) && (step != LAST_LOAD_STEP) && !in_valid) begin
                underrun <= 1'b1;
            end
            out_valid <= capture;
            out_last  <= cap_last;
            if (capture) begin
                out_data <= y;
            end
            if (cap_last) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft4_sched.sv
// Self-checking bench for fft4_sched with a 4-cycle delay standing in for the datapath.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fft4_sched;

    logic       clk;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] a;
    logic       sel;
    logic       sel_1;
    logic [3:0] y;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic       underrun;
    logic [7:0] frame_count;

    fft4_sched #(.DW(4), .LAT(4)) dut (
        .clk         (clk),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .a           (a),
        .sel         (sel),
        .sel_1       (sel_1),
        .y           (y),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: y is a delayed by four cycles.
    logic [3:0] ypipe [4];
    always @(posedge clk) begin
        ypipe[0] <= a;
        ypipe[1] <= ypipe[0];
        ypipe[2] <= ypipe[1];
        ypipe[3] <= ypipe[2];
    end
    assign y = ypipe[3];

    typedef struct packed {
        logic [3:0] d;
        logic       l;
    } sb_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] dat;
        logic       rdy;
        logic [3:0] a;
        logic       sel;
        logic       sel1;
        logic       busy;
    } vec_t;

    sb_t        sb [$];
    sb_t        mon_e;
    int         n_chk = 0;
    int         n_fail = 0;
    int         ov_cnt = 0;
    int         ov_mark;
    int         npush;
    logic [7:0] exp_fc = 8'd0;
    logic       exp_ur = 1'b0;
    vec_t       tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: every out_valid beat must match the next scoreboard entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_cnt++;
            if (sb.size() == 0) begin
                chk("out_valid with empty scoreboard", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.d));
                chk("out_last", 32'(out_last), 32'(mon_e.l));
                if (mon_e.l) begin
                    exp_fc = exp_fc + 8'd1;
                    chk("frame_count at out_last", 32'(frame_count), 32'(exp_fc));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 4'd0;
        end
    endtask

    // Drives one frame starting in a cycle where x0 can be accepted (IDLE or step 7);
    // returns after step 6 so the caller's next cycle is step 7.
    task automatic drive_frame(input logic [3:0] x0, input logic [3:0] x1,
                               input logic [3:0] x2, input logic [3:0] x3,
                               input int drop, input logic b2b);
        logic [3:0] xs [4];
        logic [3:0] ea [4];
        logic       e1;
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = (k != drop);
            in_data  = xs[k];
            ea[k]    = (k != drop) ? xs[k] : 4'd0;
            if (k == drop) exp_ur = 1'b1;
            #1;
            if (k == 0) begin
                chk("in_ready at frame start", 32'(in_ready), 32'd1);
            end else begin
                e1 = (k - 1 < 2) ? b2b : 1'b0;
                chk("a in load", 32'(a), 32'(ea[k-1]));
                chk("sel_1 in load", 32'(sel_1), 32'(e1));
                chk("busy in load", 32'(busy), 32'd1);
            end
            sb.push_back('{d: ea[k], l: (k == 3)});
        end
        for (int s = 3; s < 7; s++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 4'd0;
            #1;
            if (s == 3) begin
                chk("a at step 3", 32'(a), 32'(ea[3]));
                chk("in_ready at step 3", 32'(in_ready), 32'd0);
                chk("underrun at step 3", 32'(underrun), 32'(exp_ur));
            end
            if (s == 4) chk("a at step 4", 32'(a), 32'd0);
        end
    endtask

    initial begin
        //            vld  dat   rdy  a     sel  sel1 busy
        tbl[0]  = '{1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'd3, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'd2, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};

        // Reset held three cycles with a sample offered.
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("outputs during clear",
                32'({a, sel, sel_1, out_valid, out_data, out_last, underrun, frame_count, busy}), 32'd0);
            chk("in_ready during clear", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("in_ready after clear", 32'(in_ready), 32'd1);
        chk("busy after clear", 32'(busy), 32'd0);

        // Single frame 5,3,2,7 from the vector table.
        ov_mark = ov_cnt;
        npush   = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = tbl[i].vld;
            in_data  = tbl[i].dat;
            #1;
            chk($sformatf("in_ready row %0d", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("a row %0d", i), 32'(a), 32'(tbl[i].a));
            chk($sformatf("sel row %0d", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("sel_1 row %0d", i), 32'(sel_1), 32'(tbl[i].sel1));
            chk($sformatf("busy row %0d", i), 32'(busy), 32'(tbl[i].busy));
            if (tbl[i].vld && tbl[i].rdy) begin
                sb.push_back('{d: tbl[i].dat, l: (npush == 3)});
                npush++;
            end
        end
        idle(4);
        chk("single frame out_valid beats", 32'(ov_cnt - ov_mark), 32'd4);
        chk("single frame count", 32'(frame_count), 32'd1);
        chk("single frame underrun", 32'(underrun), 32'd0);

        // Back-to-back frames.
        ov_mark = ov_cnt;
        drive_frame(4'd5, 4'd3, 4'd2, 4'd7, -1, 1'b0);
        drive_frame(4'd3, 4'd15, 4'd2, 4'd15, -1, 1'b1);
        idle(12);
        chk("b2b out_valid beats", 32'(ov_cnt - ov_mark), 32'd8);
        chk("b2b frame count", 32'(frame_count), 32'd3);

        // Underrun: sample missing at step 1 is zero on a at step 2.
        drive_frame(4'd9, 4'd4, 4'd1, 4'd6, 2, 1'b0);
        idle(12);
        chk("underrun sticky", 32'(underrun), 32'd1);
        chk("underrun frame count", 32'(frame_count), 32'd4);

        // Clean slate, then clear mid-frame at step 5.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        sb.delete();
        exp_fc = 8'd0;
        exp_ur = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("underrun cleared", 32'(underrun), 32'd0);
        chk("frame_count cleared", 32'(frame_count), 32'd0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd9;
        sb.push_back('{d: 4'd9, l: 1'b0});
        @(negedge clk);
        in_data = 4'd1;
        sb.push_back('{d: 4'd1, l: 1'b0});
        @(negedge clk);
        in_data = 4'd4;
        sb.push_back('{d: 4'd4, l: 1'b0});
        @(negedge clk);
        in_data = 4'd6;
        sb.push_back('{d: 4'd6, l: 1'b1});
        idle(2);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        #1;
        chk("in_ready while clear mid-frame", 32'(in_ready), 32'd0);
        chk("out_valid before mid-frame clear", 32'(out_valid), 32'd1);
        @(posedge clk);
        sb.delete();
        ov_mark = ov_cnt;
        @(negedge clk);
        clear = 1'b0;
        idle(12);
        chk("no out_valid after mid-frame clear", 32'(ov_cnt - ov_mark), 32'd0);
        chk("frame_count after mid-frame clear", 32'(frame_count), 32'd0);
        chk("busy after mid-frame clear", 32'(busy), 32'd0);

        // 256 back-to-back frames wrap the frame counter to zero.
        for (int f = 0; f < 256; f++) begin
            drive_frame(4'($urandom_range(15)), 4'($urandom_range(15)),
                        4'($urandom_range(15)), 4'($urandom_range(15)), -1, (f > 0));
        end
        idle(12);
        chk("frame_count wrap", 32'(frame_count), 32'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
